// File: rtl/uart_receiver_if.sv
`timescale 1ns/1ps
// Receiver-side UART bundle: serial line, enable and rate code in; received byte and status out.
interface uart_receiver_if;
  logic [2:0] baud_select;
  logic       Rx_EN;
  logic       Rx_D;
  logic [7:0] Rx_DATA;
  logic       Rx_VALID;
  logic       Rx_FERROR;
  logic       Rx_PERROR;

  modport master (
    output baud_select, Rx_EN, Rx_D,
    input  Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR
  );

  modport slave (
    input  baud_select, Rx_EN, Rx_D,
    output Rx_DATA, Rx_VALID, Rx_FERROR, Rx_PERROR
  );
endinterface

// File: rtl/uart_receiver.sv
`timescale 1ns/1ps
// 16x-oversampling UART receiver, 8 data bits, LSB first.
// Define UART_RX_PARITY_EN for an even-parity bit between data and stop; otherwise Rx_PERROR is 0.
module uart_receiver (
  input  logic           clk,
  input  logic           reset,
  uart_receiver_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t      state_q;
  logic        sync1_q;
  logic        sync2_q;
  logic        prev_q;
  logic [2:0]  baud_q;
  logic [14:0] div_q;
  logic [14:0] div_last;
  logic [3:0]  tick_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [7:0]  data_q;
  logic        valid_q;
  logic        ferror_q;
  logic        tick;
  logic        start_det;
  logic        sample;
`ifdef UART_RX_PARITY_EN
  logic        par_err_q;
  logic        perror_q;
`endif

  // Last count of the 16x tick divider for each rate code (period minus one).
  function automatic logic [14:0] div_last_for(input logic [2:0] code);
    case (code)
      3'd0:    div_last_for = 15'd20832;
      3'd1:    div_last_for = 15'd5207;
      3'd2:    div_last_for = 15'd1301;
      3'd3:    div_last_for = 15'd650;
      3'd4:    div_last_for = 15'd325;
      3'd5:    div_last_for = 15'd162;
      3'd6:    div_last_for = 15'd108;
      default: div_last_for = 15'd53;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= bus.Rx_D;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // A start needs a real high-to-low transition, so a line already low when enabled is ignored.
  assign start_det = (state_q == IDLE) && bus.Rx_EN && prev_q && !sync2_q;
  assign div_last  = div_last_for(baud_q);
  assign tick      = (div_q == div_last);
  assign sample    = tick && (tick_cnt_q == ((state_q == START) ? 4'd7 : 4'd15));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else if (start_det || tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 15'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferror_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q  <= 1'b0;
      perror_q   <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (state_q != IDLE && tick) begin
        tick_cnt_q <= sample ? 4'd0 : tick_cnt_q + 4'd1;
      end
      if (state_q != IDLE && !bus.Rx_EN) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_det) begin
              state_q    <= START;
              baud_q     <= bus.baud_select;
              tick_cnt_q <= '0;
              bit_cnt_q  <= '0;
            end
          end
          START: begin
            // A line back high at mid-start was a glitch.
            if (sample) state_q <= sync2_q ? IDLE : DATA;
          end
          DATA: begin
            if (sample) begin
              shift_q   <= {sync2_q, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_q <= PARITY;
`else
                state_q <= STOP;
`endif
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (sample) begin
              par_err_q <= ^{shift_q, sync2_q};
              state_q   <= STOP;
            end
          end
`endif
          STOP: begin
            // Leaving at mid-stop lets a following start bit arrive with no idle gap.
            if (sample) begin
              data_q   <= shift_q;
              ferror_q <= !sync2_q;
`ifdef UART_RX_PARITY_EN
              perror_q <= par_err_q;
`endif
              valid_q  <= 1'b1;
              state_q  <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.Rx_DATA   = data_q;
  assign bus.Rx_VALID  = valid_q;
  assign bus.Rx_FERROR = ferror_q;
`ifdef UART_RX_PARITY_EN
  assign bus.Rx_PERROR = perror_q;
`else
  assign bus.Rx_PERROR = 1'b0;
`endif
endmodule

// File: tb/tb_uart_receiver.sv
`timescale 1ns/1ps
// Bench for uart_receiver at 115200 baud (864 clk per bit); frame format follows UART_RX_PARITY_EN.
module tb_uart_receiver;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FLEN = PAR_EN ? 11 : 10;
  localparam int BIT  = 864;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  uart_receiver_if bus();
  uart_receiver dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;
  int unsigned v_cyc[$];
  logic [9:0]  v_val[$];
  logic [9:0]  exp_out;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.Rx_VALID === 1'b1) begin
      v_cyc.push_back(cyc);
      v_val.push_back({bus.Rx_DATA, bus.Rx_FERROR, bus.Rx_PERROR});
    end
  end

  function automatic logic [9:0] outs();
    return {bus.Rx_DATA, bus.Rx_FERROR, bus.Rx_PERROR};
  endfunction

  // Line bits in transmission order: bit 0 is the start bit.
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic par, input logic stp);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
    if (PAR_EN) begin
      f[9]  = par;
      f[10] = stp;
    end else begin
      f[9] = stp;
    end
    return f;
  endfunction

  // Expected {data, framing error, parity error} for a completed frame.
  function automatic logic [9:0] model(input logic [7:0] d, input logic par, input logic stp);
    logic pe;
    pe = PAR_EN ? ((^d) ^ par) : 1'b0;
    return {d, ~stp, pe};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.Rx_D = f[i];
      idle(BIT);
    end
  endtask

  task automatic clear_mon();
    v_cyc.delete();
    v_val.delete();
  endtask

  task automatic test_reset();
    bus.Rx_D = 1'b1;
    bus.Rx_EN = 1'b1;
    bus.baud_select = 3'd7;
    #2 reset = 1'b0;
    #1;
    exp_out = '0;
    tests++;
    if (outs() !== exp_out) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h", outs(), exp_out);
    end
    tests++;
    if (bus.Rx_VALID !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid: got %b expected 0", bus.Rx_VALID);
    end
    idle(5);
    reset = 1'b1;
    clear_mon();
    idle(20);
    tests++;
    if (v_val.size() != 0 || outs() !== exp_out) begin
      fails++;
      $display("FAIL reset_release: pulses %0d outputs %h expected 0 pulses outputs %h", v_val.size(), outs(), exp_out);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_single_frame();
    logic [7:0]  d;
    logic [10:0] f;
    int unsigned t0;
    int          lat;
    int          exp_lat;
    d = 8'h0F;
    f = mk_frame(d, ^d, 1'b1);
    clear_mon();
    t0 = cyc;
    drive_bits(f, FLEN);
    idle(4);
    exp_out = model(d, ^d, 1'b1);
    exp_lat = (2 * FLEN - 1) * BIT / 2;
    lat = (v_cyc.size() > 0) ? int'(v_cyc[0] - t0) : -1;
    tests++;
    if (v_val.size() != 1) begin
      fails++;
      $display("FAIL single_count: got %0d pulses expected 1", v_val.size());
    end
    tests++;
    if (outs() !== exp_out) begin
      fails++;
      $display("FAIL single_outputs: got %h expected %h", outs(), exp_out);
    end
    tests++;
    if (lat < exp_lat || lat > exp_lat + 16) begin
      fails++;
      $display("FAIL single_latency: got %0d clk expected %0d..%0d", lat, exp_lat, exp_lat + 16);
    end
    $display("[TB] frame %h latency %0d clk", d, lat);
  endtask

  task automatic test_back_to_back();
    logic [7:0] da;
    logic [7:0] db;
    logic [9:0] got;
    int         gap;
    da = 8'hEA;
    db = 8'h0F;
    clear_mon();
    drive_bits(mk_frame(da, ^da, 1'b1), FLEN);
    drive_bits(mk_frame(db, ^db, 1'b1), FLEN);
    idle(4);
    tests++;
    if (v_val.size() != 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d pulses expected 2", v_val.size());
    end
    got = (v_val.size() > 0) ? v_val[0] : 'x;
    tests++;
    if (got !== model(da, ^da, 1'b1)) begin
      fails++;
      $display("FAIL b2b_first: got %h expected %h", got, model(da, ^da, 1'b1));
    end
    got = (v_val.size() > 1) ? v_val[1] : 'x;
    tests++;
    if (got !== model(db, ^db, 1'b1)) begin
      fails++;
      $display("FAIL b2b_second: got %h expected %h", got, model(db, ^db, 1'b1));
    end
    gap = (v_cyc.size() > 1) ? int'(v_cyc[1] - v_cyc[0]) : -1;
    tests++;
    if (gap < FLEN * BIT - 2 || gap > FLEN * BIT + 2) begin
      fails++;
      $display("FAIL b2b_spacing: got %0d clk expected %0d", gap, FLEN * BIT);
    end
    exp_out = model(db, ^db, 1'b1);
    $display("[TB] back-to-back %h %h gap %0d clk", da, db, gap);
  endtask

  task automatic test_glitch();
    int hold;
    clear_mon();
    bus.Rx_D = 1'b0;
    idle(300);
    bus.Rx_D = 1'b1;
    idle(BIT);
    tests++;
    if (v_val.size() != 0 || outs() !== exp_out) begin
      fails++;
      $display("FAIL glitch: pulses %0d outputs %h expected 0 pulses outputs %h", v_val.size(), outs(), exp_out);
    end
    hold = $urandom_range(100, 400);
    bus.Rx_EN = 1'b0;
    bus.Rx_D = 1'b0;
    idle(hold);
    bus.Rx_EN = 1'b1;
    idle(BIT);
    bus.Rx_D = 1'b1;
    idle(BIT);
    tests++;
    if (v_val.size() != 0 || outs() !== exp_out) begin
      fails++;
      $display("FAIL held_low: pulses %0d outputs %h expected 0 pulses outputs %h", v_val.size(), outs(), exp_out);
    end
    $display("[TB] glitch 300 clk and held-low line (%0d clk) ignored", hold);
  endtask

  task automatic test_framing_error();
    logic [7:0] d;
    d = 8'h55;
    clear_mon();
    drive_bits(mk_frame(d, ^d, 1'b0), FLEN);
    bus.Rx_D = 1'b1;
    idle(BIT);
    exp_out = model(d, ^d, 1'b0);
    tests++;
    if (v_val.size() != 1 || outs() !== exp_out) begin
      fails++;
      $display("FAIL ferror_frame: pulses %0d outputs %h expected 1 pulse outputs %h", v_val.size(), outs(), exp_out);
    end
    $display("[TB] frame %h bad stop -> outputs %h", d, outs());
    d = 8'($urandom_range(0, 255));
    clear_mon();
    drive_bits(mk_frame(d, ^d, 1'b1), FLEN);
    idle(4);
    exp_out = model(d, ^d, 1'b1);
    tests++;
    if (v_val.size() != 1 || outs() !== exp_out) begin
      fails++;
      $display("FAIL ferror_clear: pulses %0d outputs %h expected 1 pulse outputs %h", v_val.size(), outs(), exp_out);
    end
    $display("[TB] frame %h good stop -> outputs %h", d, outs());
  endtask

  task automatic test_parity_error();
    logic [7:0] d;
    d = 8'h01;
    clear_mon();
    drive_bits(mk_frame(d, 1'b0, 1'b1), FLEN);
    idle(4);
    exp_out = model(d, 1'b0, 1'b1);
    tests++;
    if (v_val.size() != 1) begin
      fails++;
      $display("FAIL perror_count: got %0d pulses expected 1", v_val.size());
    end
    tests++;
    if (outs() !== exp_out) begin
      fails++;
      $display("FAIL perror_outputs: got %h expected %h", outs(), exp_out);
    end
    $display("[TB] frame %h parity bit 0 -> outputs %h", d, outs());
  endtask

  task automatic test_enable_abort();
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    clear_mon();
    drive_bits(mk_frame(d, ^d, 1'b1), 4);
    bus.Rx_EN = 1'b0;
    idle(2);
    bus.Rx_D = 1'b1;
    idle(10);
    bus.Rx_EN = 1'b1;
    idle(7 * BIT);
    tests++;
    if (v_val.size() != 0 || outs() !== exp_out) begin
      fails++;
      $display("FAIL enable_abort: pulses %0d outputs %h expected 0 pulses outputs %h", v_val.size(), outs(), exp_out);
    end
    $display("[TB] frame %h aborted by Rx_EN", d);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0]  d;
    logic [10:0] f;
    d = 8'hA5;
    f = mk_frame(d, ^d, 1'b1);
    clear_mon();
    drive_bits(f, 5);
    bus.Rx_D = f[5];
    idle(BIT / 2);
    reset = 1'b0;
    bus.Rx_D = 1'b1;
    #1;
    exp_out = '0;
    tests++;
    if (outs() !== exp_out || bus.Rx_VALID !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: outputs %h valid %b expected %h valid 0", outs(), bus.Rx_VALID, exp_out);
    end
    idle(5);
    reset = 1'b1;
    idle($urandom_range(20, 200));
    tests++;
    if (v_val.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_pulse: got %0d pulses expected 0", v_val.size());
    end
    d = 8'h3C;
    clear_mon();
    drive_bits(mk_frame(d, ^d, 1'b1), FLEN);
    idle(4);
    exp_out = model(d, ^d, 1'b1);
    tests++;
    if (v_val.size() != 1 || outs() !== exp_out) begin
      fails++;
      $display("FAIL reset_recover: pulses %0d outputs %h expected 1 pulse outputs %h", v_val.size(), outs(), exp_out);
    end
    $display("[TB] reset during A5, then frame %h -> outputs %h", d, outs());
  endtask

  initial begin
    bus.Rx_D = 1'b1;
    bus.Rx_EN = 1'b0;
    bus.baud_select = 3'd7;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_framing_error();
    test_parity_error();
    test_enable_abort();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 clk  input  1  system clock, 100 MHz, rising edge; sole clock domain.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 baud_select  input  3  rate code, same encoding as the transmitter.
REQ-004 Rx_EN  input  1  receiver enable; low = idle, frames ignored.
REQ-005 Rx_D  input  1  serial line from transmitter Tx_D; asynchronous, idles high.
REQ-006 Rx_DATA  output  8  last received byte.
REQ-007 Rx_VALID  output  1  one-clk pulse on frame completion.
REQ-008 Rx_FERROR  output  1  framing error of last completed frame.
REQ-009 Rx_PERROR  output  1  parity error of last completed frame.

Function
REQ-010 Rx_D SHALL pass through a 2-flop synchronizer, reset value 1; all decisions use the synchronized line.
REQ-011 A 16x sample tick SHALL come from a free-running divider reloaded per baud_select: 000..111 = 300, 1200, 4800, 9600, 19200, 38400, 57600, 115200 baud, i.e. 20833, 5208, 1302, 651, 326, 163, 109, 54 clk.
REQ-012 baud_select SHALL be latched at start-bit detection and held for the frame; changes mid-frame take effect on the next frame.
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE->START on a synchronized 1->0 transition while Rx_EN=1; tick counter clears, divider restarts.
REQ-015 START: after 8 ticks the line is re-sampled; 0 -> DATA, 1 (glitch) -> IDLE with no output change.
REQ-016 DATA: 8 bits sampled every 16 ticks (mid-bit), LSB first, into a shift register.
REQ-017 PARITY: one bit sampled 16 ticks after the last data bit; error if data plus parity bit is not even.
REQ-018 STOP: sampled 16 ticks after the preceding bit; 0 sets framing error.
REQ-019 On the stop sample, on the next clk edge: Rx_DATA loads the shifted byte, Rx_FERROR/Rx_PERROR load this frame's flags, Rx_VALID=1 for exactly one clk, FSM -> IDLE.
REQ-020 Rx_DATA, Rx_FERROR and Rx_PERROR SHALL hold until the next frame completes; errored frames still load Rx_DATA and pulse Rx_VALID.
REQ-021 Return to IDLE at mid-stop SHALL allow a back-to-back start bit to be detected with no idle gap.
REQ-022 Rx_EN falling mid-frame SHALL abort to IDLE on the next clk; no Rx_VALID, outputs unchanged.
REQ-023 Line low in IDLE with no preceding high (e.g. enabled on a held-low line) SHALL NOT start a frame.

Reset
REQ-024 reset low SHALL immediately force: FSM IDLE, counters 0, synchronizer 1, Rx_DATA 8'h00, Rx_VALID 0, Rx_FERROR 0, Rx_PERROR 0.
REQ-025 Reset mid-frame SHALL discard the partial frame; the first frame after release is received normally.

Configuration
REQ-026 Macro UART_RX_PARITY_EN defined: 11-bit frame (start, 8 data, even parity, stop), PARITY state present.
REQ-027 Macro UART_RX_PARITY_EN undefined: 10-bit frame, DATA->STOP directly, Rx_PERROR tied 0; transmitter built to match.

Verification (baud_select=111, 864 clk/bit, parity enabled unless noted)
REQ-028 Frame 0x0F, parity 0 -> one Rx_VALID pulse about 10.5 bit times after start edge, Rx_DATA=0x0F, both error flags 0.
REQ-029 Back-to-back 0xEA then 0x0F, no idle gap -> two Rx_VALID pulses 11 bit times apart, Rx_DATA 0xEA then 0x0F.
REQ-030 Line low 300 clk in IDLE -> no Rx_VALID, FSM back in IDLE, outputs unchanged.
REQ-031 Frame 0x55 with stop bit 0 -> Rx_VALID pulse, Rx_DATA=0x55, Rx_FERROR=1; next good frame clears it to 0.
REQ-032 Frame 0x01 with parity bit 0 -> Rx_PERROR=1; with macro undefined the same 10-bit frame gives Rx_PERROR=0.
REQ-033 reset low during bit 4 of 0xA5 -> outputs at reset values at once, no Rx_VALID; next 0x3C frame received correctly.
